// File: rtl/qcl_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
package qcl_pipe_pkg;

   // Receive FIFO fill level at or below which upstream is allowed to send.
   localparam int unsigned ready_thresh_c = 2;

   // The receive FIFO must absorb every word that is already in flight when
   // the ready threshold is crossed. That is one forward trip plus one
   // backward trip, plus margin.
   function automatic int unsigned fifo_depth_f(input int unsigned stages);
      return 2 * stages + 4;
   endfunction

endpackage

// File: rtl/qcl_pipe_elastic_fifo.sv
// First-word-fall-through receive FIFO. The depth need not be a power of two.
// A push into a full FIFO is dropped, unless a pop happens in the same cycle,
// and the sticky overflow flag is set.
module qcl_pipe_elastic_fifo #(
   parameter int width_p = 32,
   parameter int depth_p = 8
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             push_i,
   input  logic [width_p-1:0]               push_data_i,
   input  logic                             pop_i,
   output logic                             valid_o,
   output logic [width_p-1:0]               data_o,
   output logic [$clog2(depth_p+1)-1:0]     count_o,
   output logic                             overflow_o
);

   localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
   localparam int cnt_w = $clog2(depth_p + 1);
   localparam logic [ptr_w-1:0] last_ptr_c = ptr_w'(depth_p - 1);
   localparam logic [cnt_w-1:0] full_c     = cnt_w'(depth_p);

   logic [width_p-1:0] mem_r [depth_p];
   logic [ptr_w-1:0]   wr_ptr_r;
   logic [ptr_w-1:0]   rd_ptr_r;
   logic [cnt_w-1:0]   count_r;
   logic               overflow_r;
   logic               pop;
   logic               full;
   logic               wr_en;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == last_ptr_c) ? '0 : p + ptr_w'(1);
   endfunction

   assign valid_o    = (count_r != '0);
   assign data_o     = mem_r[rd_ptr_r];
   assign count_o    = count_r;
   assign overflow_o = overflow_r;
   assign pop        = pop_i & valid_o;
   assign full       = (count_r == full_c);
   // When the FIFO is full, a same-cycle pop frees the head slot. The write
   // pointer equals the read pointer in that case, so the new word lands in
   // the slot being vacated.
   assign wr_en      = push_i & (~full | pop);

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (pop)   rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({wr_en, pop})
            2'b10:   count_r <= count_r + cnt_w'(1);
            2'b01:   count_r <= count_r - cnt_w'(1);
            default: count_r <= count_r;
         endcase
         if (push_i & full & ~pop) overflow_r <= 1'b1;
      end
   end

   // Storage array. It is not reset because the pointers qualify every read.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_r[wr_ptr_r] <= push_data_i;
   end

endmodule

// File: rtl/qcl_pipe_elastic.sv
// Elastic pipeline. A registered forward chain carries {valid,data} and a
// registered backward chain carries ready. The receive FIFO at the far end is
// deep enough to soak up every word still in flight when it asserts
// back-pressure. No input reaches any output combinationally.
module qcl_pipe_elastic
   import qcl_pipe_pkg::*;
#(
   parameter int width_p  = 32,
   parameter int stages_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               valid_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               valid_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i,
   output logic               overflow_o
);

   localparam int depth_c = int'(fifo_depth_f(stages_p));
   localparam int cnt_w   = $clog2(depth_c + 1);

   logic [stages_p-1:0] fwd_valid_r;
   logic [width_p-1:0]  fwd_data_r [stages_p];
   logic [stages_p-1:0] bwd_ready_r;
   logic [cnt_w-1:0]    fifo_count;
   logic                xfer;
   logic                ready_int;

   assign ready_o   = bwd_ready_r[stages_p-1];
   assign xfer      = valid_i & ready_o;
   assign ready_int = (fifo_count <= cnt_w'(ready_thresh_c));

   // Valid and ready chains. These bits are reset so that no bubble or
   // stale ready survives a reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fwd_valid_r <= '0;
         bwd_ready_r <= '0;
      end else begin
         fwd_valid_r[0] <= xfer;
         bwd_ready_r[0] <= ready_int;
         for (int i = 1; i < stages_p; i++) begin
            fwd_valid_r[i] <= fwd_valid_r[i-1];
            bwd_ready_r[i] <= bwd_ready_r[i-1];
         end
      end
   end

   // Forward data chain. It is not reset, and a stage loads only when the
   // stage feeding it holds a real word.
   always_ff @(posedge clk_i) begin
      if (xfer) fwd_data_r[0] <= data_i;
      for (int i = 1; i < stages_p; i++) begin
         if (fwd_valid_r[i-1]) fwd_data_r[i] <= fwd_data_r[i-1];
      end
   end

   qcl_pipe_elastic_fifo #(
      .width_p (width_p),
      .depth_p (depth_c)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .push_i      (fwd_valid_r[stages_p-1]),
      .push_data_i (fwd_data_r[stages_p-1]),
      .pop_i       (ready_i),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .count_o     (fifo_count),
      .overflow_o  (overflow_o)
   );

endmodule

// File: tb/tb_qcl_pipe_elastic.sv
// Directed and randomized bench for qcl_pipe_elastic.
// Inputs are driven on the falling edge and registered outputs are sampled
// there too.
module tb_qcl_pipe_elastic;

   localparam int S = 2;

   logic        clk;
   logic        reset_n;
   logic        valid_i;
   logic [31:0] data_i;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] data_o;
   logic        ready_i;
   logic        overflow_o;
   logic [3:0]  dut_count;

   logic        r_valid;
   logic        r_ready;
   logic [31:0] r_data   [3];
   logic [2:0]  r_ready_o;
   logic [2:0]  r_valid_o;
   logic [31:0] r_data_o [3];
   logic [2:0]  r_ovf;

   int tests_run;
   int tests_failed;

   qcl_pipe_elastic #(.width_p(32), .stages_p(S)) u_dut (
      .clk_i      (clk),
      .reset_n_i  (reset_n),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .ready_i    (ready_i),
      .overflow_o (overflow_o)
   );

   assign dut_count = u_dut.u_fifo.count_r;

   for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
      localparam int SP = (gi == 0) ? 1 : (gi == 1) ? 3 : 16;
      qcl_pipe_elastic #(.width_p(32), .stages_p(SP)) u_rnd (
         .clk_i      (clk),
         .reset_n_i  (reset_n),
         .valid_i    (r_valid),
         .data_i     (r_data[gi]),
         .ready_o    (r_ready_o[gi]),
         .valid_o    (r_valid_o[gi]),
         .data_o     (r_data_o[gi]),
         .ready_i    (r_ready),
         .overflow_o (r_ovf[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_low got %b exp 0", ready_o); end
      tests_run++;
      if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_low got %b exp 0", valid_o); end
      tests_run++;
      if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b exp 0", overflow_o); end
      tests_run++;
      if (dut_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", dut_count); end
      reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         tests_run++;
         if (ready_o !== (k >= S)) begin
            tests_failed++;
            $display("FAIL release_ready k=%0d got %b exp %b", k, ready_o, (k >= S));
         end
         tests_run++;
         if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL release_valid k=%0d got %b exp 0", k, valid_o); end
      end
   endtask

   task automatic test_single();
      int waited;
      ready_i = 1'b1;
      waited  = 0;
      while (ready_o !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      tests_run++;
      if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL single_ready_timeout got %b exp 1", ready_o); end
      valid_i = 1'b1;
      data_i  = 32'hA5A5_A5A5;
      tests_run++;
      if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_valid j=0 got %b exp 0", valid_o); end
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         valid_i = 1'b0;
         data_i  = 32'h0;
         tests_run++;
         if (valid_o !== (j == S + 1)) begin
            tests_failed++;
            $display("FAIL single_valid j=%0d got %b exp %b", j, valid_o, (j == S + 1));
         end
         if (j == S + 1) begin
            tests_run++;
            if (data_o !== 32'hA5A5_A5A5) begin
               tests_failed++;
               $display("FAIL single_data got %h exp a5a5a5a5", data_o);
            end
         end
      end
   endtask

   task automatic test_stream();
      int sent, rcvd, gaps;
      bit started;
      sent = 0; rcvd = 0; gaps = 0; started = 0;
      ready_i = 1'b1;
      for (int cyc = 0; cyc < 300 && rcvd < 100; cyc++) begin
         @(negedge clk);
         if (valid_o) begin
            started = 1;
            tests_run++;
            if (data_o !== 32'(rcvd)) begin
               tests_failed++;
               $display("FAIL stream_data idx=%0d got %0d exp %0d", rcvd, data_o, rcvd);
            end
            rcvd++;
         end else if (started) begin
            gaps++;
         end
         valid_i = (sent < 100);
         data_i  = 32'(sent);
         if (valid_i && ready_o) sent++;
      end
      valid_i = 1'b0;
      tests_run++;
      if (rcvd != 100) begin tests_failed++; $display("FAIL stream_count got %0d exp 100", rcvd); end
      tests_run++;
      if (gaps != 0) begin tests_failed++; $display("FAIL stream_gaps got %0d exp 0", gaps); end
   endtask

   task automatic test_backpressure();
      int sent, rcvd, peak, gt2_cyc, fall_cyc;
      sent = 0; rcvd = 0; peak = 0; gt2_cyc = -1; fall_cyc = -1;
      for (int cyc = 0; cyc < 400 && rcvd < 40; cyc++) begin
         @(negedge clk);
         ready_i = (cyc >= 20);
         if (valid_o && ready_i) begin
            tests_run++;
            if (data_o !== 32'(rcvd)) begin
               tests_failed++;
               $display("FAIL bp_data idx=%0d got %0d exp %0d", rcvd, data_o, rcvd);
            end
            rcvd++;
         end
         if (int'(dut_count) > peak) peak = int'(dut_count);
         if (gt2_cyc < 0 && dut_count > 4'd2) gt2_cyc = cyc;
         if (gt2_cyc >= 0 && fall_cyc < 0 && !ready_o) fall_cyc = cyc;
         valid_i = (sent < 40);
         data_i  = 32'(sent);
         if (valid_i && ready_o) sent++;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      tests_run++;
      if (rcvd != 40) begin tests_failed++; $display("FAIL bp_count got %0d exp 40", rcvd); end
      tests_run++;
      if (peak > 8 || peak <= 2) begin tests_failed++; $display("FAIL bp_peak got %0d exp 3..8", peak); end
      tests_run++;
      if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL bp_overflow got %b exp 0", overflow_o); end
      tests_run++;
      if (fall_cyc < 0 || fall_cyc - gt2_cyc > S + 1) begin
         tests_failed++;
         $display("FAIL bp_ready_fall got %0d cycles exp <= %0d", fall_cyc - gt2_cyc, S + 1);
      end
   endtask

   task automatic test_random();
      int sent [3];
      int expv [3];
      for (int i = 0; i < 3; i++) begin sent[i] = 0; expv[i] = 0; end
      for (int cyc = 0; cyc < 3300; cyc++) begin
         @(negedge clk);
         if (cyc < 3000) begin
            r_valid = 1'($urandom_range(0, 1));
            r_ready = 1'($urandom_range(0, 1));
         end else begin
            r_valid = 1'b0;
            r_ready = 1'b1;
         end
         for (int i = 0; i < 3; i++) begin
            if (r_valid_o[i] && r_ready) begin
               tests_run++;
               if (r_data_o[i] !== 32'(expv[i])) begin
                  tests_failed++;
                  $display("FAIL rand_data inst=%0d got %0d exp %0d", i, r_data_o[i], expv[i]);
               end
               expv[i]++;
            end
            r_data[i] = 32'(sent[i]);
            if (r_valid && r_ready_o[i]) sent[i]++;
         end
      end
      r_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (expv[i] != sent[i] || sent[i] == 0) begin
            tests_failed++;
            $display("FAIL rand_count inst=%0d got %0d exp %0d", i, expv[i], sent[i]);
         end
         tests_run++;
         if (r_ovf[i] !== 1'b0) begin tests_failed++; $display("FAIL rand_overflow inst=%0d got %b exp 0", i, r_ovf[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int sent, stale;
      bit got;
      sent = 0; stale = 0; got = 0;
      ready_i = 1'b0;
      for (int cyc = 0; cyc < 40 && dut_count != 4'd5; cyc++) begin
         @(negedge clk);
         valid_i = (sent < 5);
         data_i  = 32'hC0 + 32'(sent);
         if (valid_i && ready_o) sent++;
      end
      valid_i = 1'b0;
      tests_run++;
      if (dut_count !== 4'd5) begin tests_failed++; $display("FAIL mid_fill got %0d exp 5", dut_count); end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      tests_run++;
      if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %b exp 0", valid_o); end
      tests_run++;
      if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL mid_ready got %b exp 0", ready_o); end
      tests_run++;
      if (dut_count !== 4'd0) begin tests_failed++; $display("FAIL mid_count got %0d exp 0", dut_count); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ready_i = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (valid_o) stale++;
      end
      tests_run++;
      if (stale != 0) begin tests_failed++; $display("FAIL mid_stale got %0d exp 0", stale); end
      valid_i = 1'b1;
      data_i  = 32'h0000_005A;
      @(negedge clk);
      valid_i = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (valid_o) begin
            got = 1;
            tests_run++;
            if (data_o !== 32'h0000_005A) begin tests_failed++; $display("FAIL mid_after_data got %h exp 0000005a", data_o); end
         end
      end
      tests_run++;
      if (!got) begin tests_failed++; $display("FAIL mid_after_timeout got none exp 0000005a"); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset_n = 1'b0;
      valid_i = 1'b0;
      data_i  = 32'h0;
      ready_i = 1'b0;
      r_valid = 1'b0;
      r_ready = 1'b0;
      for (int i = 0; i < 3; i++) r_data[i] = 32'h0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
